// File: rtl/fetch_port_arbiter_pkg.sv
// Shared constants for the prefetch-FIFO read-port arbiter: requester
// indices of the instruction-stream consumers and default sizing.
package fetch_port_arbiter_pkg;

  localparam int NUM_REQ_DEFAULT     = 3;
  localparam int COUNT_WIDTH_DEFAULT = 4;

  localparam int REQ_OPCODE = 0;
  localparam int REQ_MODRM  = 1;
  localparam int REQ_IMMED  = 2;

endpackage

// File: rtl/fetch_port_arbiter_if.sv
// Bundle between the instruction-stream consumers (master side) and the
// read-port arbiter (slave side). The release strobe is called rel_pulse
// because "release" is a reserved word in SystemVerilog.
interface fetch_port_arbiter_if
  import fetch_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEFAULT,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
);

  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     rel_pulse;
  logic [NUM_REQ-1:0]     rd_en_in;
  logic                   fifo_empty;
  logic                   flush;
  logic [NUM_REQ-1:0]     grant;
  logic                   busy;
  logic                   fifo_rd_en;
  logic [COUNT_WIDTH-1:0] bytes_consumed;
  logic                   protocol_error;

  modport master (
    output req, rel_pulse, rd_en_in, fifo_empty, flush,
    input  grant, busy, fifo_rd_en, bytes_consumed, protocol_error
  );

  modport slave (
    input  req, rel_pulse, rd_en_in, fifo_empty, flush,
    output grant, busy, fifo_rd_en, bytes_consumed, protocol_error
  );

endinterface

// File: rtl/fetch_port_arbiter_rr_priority_picker.sv
// Round-robin priority picker: returns the first set bit of req_mask at or
// after pointer, wrapping around, as a one-hot vector plus its index.
module fetch_port_arbiter_rr_priority_picker
  import fetch_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEFAULT,
  parameter int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]   req_mask,
  input  logic [PTR_WIDTH-1:0] pointer,
  output logic [NUM_REQ-1:0]   winner,
  output logic [PTR_WIDTH-1:0] winner_idx,
  output logic                 valid
);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    int idx;
    logic [PTR_WIDTH-1:0] sel;
    idx        = 0;
    sel        = '0;
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(pointer) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      sel = PTR_WIDTH'(idx);
      if (!valid && req_mask[sel]) begin
        valid       = 1'b1;
        winner[sel] = 1'b1;
        winner_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/fetch_port_arbiter.sv
// Arbiter for the single prefetch-FIFO read port. One consumer owns the
// port per grant and keeps it until it releases, drops its request, or a
// flush aborts the ownership. Ownership hands over directly to the next
// round-robin winner when someone else is waiting.
module fetch_port_arbiter
  import fetch_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEFAULT,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_port_arbiter_if.slave  bus
);

  localparam int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [PTR_WIDTH-1:0]   LAST_IDX  = PTR_WIDTH'(NUM_REQ - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state;
  logic [NUM_REQ-1:0]     grant_q;
  logic [PTR_WIDTH-1:0]   rr_ptr;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   error_q;

  logic [NUM_REQ-1:0]     pick_mask;
  logic [NUM_REQ-1:0]     winner;
  logic [PTR_WIDTH-1:0]   winner_idx;
  logic [PTR_WIDTH-1:0]   next_ptr;
  logic                   pick_valid;
  logic                   owner_done;
  logic                   rd_fire;
  logic                   stray_rd;

  // While owned, the current owner is never a candidate for the handover.
  always_comb begin
    pick_mask = bus.req;
    if (state == OWNED) begin
      pick_mask = bus.req & ~grant_q;
    end
  end

  fetch_port_arbiter_rr_priority_picker #(
    .NUM_REQ   (NUM_REQ),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_picker (
    .req_mask   (pick_mask),
    .pointer    (rr_ptr),
    .winner     (winner),
    .winner_idx (winner_idx),
    .valid      (pick_valid)
  );

  assign next_ptr   = (winner_idx == LAST_IDX) ? '0 : winner_idx + 1'b1;
  assign owner_done = (|(bus.rel_pulse & grant_q)) | ~(|(bus.req & grant_q));
  assign rd_fire    = (|(bus.rd_en_in & grant_q)) & ~bus.fifo_empty & ~bus.flush;
  assign stray_rd   = |(bus.rd_en_in & ~grant_q);

  assign bus.grant          = grant_q;
  assign bus.busy           = |grant_q;
  assign bus.fifo_rd_en     = rd_fire;
  assign bus.bytes_consumed = count_q;
  assign bus.protocol_error = error_q;

  // Ownership FSM with grant, pointer, byte counter and sticky error flag;
  // a new grant clears the counter and overrides any count in that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_ptr  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (stray_rd) begin
        error_q <= 1'b1;
      end
      if (rd_fire && (count_q != COUNT_MAX)) begin
        count_q <= count_q + 1'b1;
      end
      case (state)
        IDLE: begin
          if (!bus.flush && pick_valid) begin
            state   <= OWNED;
            grant_q <= winner;
            rr_ptr  <= next_ptr;
            count_q <= '0;
          end
        end
        OWNED: begin
          if (bus.flush) begin
            state   <= IDLE;
            grant_q <= '0;
          end else if (owner_done) begin
            if (pick_valid) begin
              grant_q <= winner;
              rr_ptr  <= next_ptr;
              count_q <= '0;
            end else begin
              state   <= IDLE;
              grant_q <= '0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
